pipe_hazard_unit: RTL and testbench
===================================

PIPE_HAZARD_UNIT -- requirements
Module: pipe_hazard_unit

Interface
REQ-001 SHALL have parameter REG_AW, default 5: register address width.
REQ-002 SHALL have parameter DEPTH, default 3: producer stages tracked after ID (index 0 = EXE, 1 = MEM, 2 = WB).
REQ-003 SHALL have parameter LOAD_LAT, default 1: stages after EXE before load data can be forwarded; legal range 1..DEPTH-1.
REQ-004 SHALL have derived localparam FWD_W = clog2(DEPTH+1).
REQ-005 SHALL have port clk, in, 1: single clock, rising edge.
REQ-006 SHALL have port rst, in, 1: asynchronous active-high reset.
REQ-007 SHALL have ports id_valid, id_rs_used, id_rt_used, id_wen and id_is_load, in, 1 each: ID-stage instruction attributes.
REQ-008 SHALL have ports id_rs_addr, id_rt_addr and id_waddr, in, REG_AW each.
REQ-009 SHALL have port mem_busy, in, 1: memory wait request; freezes the whole pipe.
REQ-010 SHALL have port cnt_clr, in, 1: synchronous clear of stall_cnt.
REQ-011 SHALL have ports fwd_a and fwd_b, out, FWD_W each: 0 = register file, k+1 = tracking stage k.
REQ-012 SHALL have port stall, out, 1: load-use hazard detected in ID.
REQ-013 SHALL have ports if_en and id_en, out, 1 each: front-end advance enables.
REQ-014 SHALL have port exe_rst, out, 1: inserts a bubble into EXE.
REQ-015 SHALL have port back_en, out, 1: enable for EXE..WB stages.
REQ-016 SHALL have port stall_cnt, out, 16: saturating count of stall cycles.

Function
REQ-017 SHALL keep a tracking shift register trk[0..DEPTH-1], each entry {valid, waddr, is_load}.
REQ-018 Freeze SHALL equal mem_busy, or the debug halt described in REQ-031/032.
REQ-019 When not frozen and not stalled, each cycle SHALL load trk[0] with the ID entry and shift trk[i] into trk[i+1]. The ID entry is valid only if id_valid, id_wen and id_waddr != 0.
REQ-020 When stall is asserted and the pipe is not frozen, trk[0] SHALL become empty and the remaining entries SHALL still shift.
REQ-021 When frozen, trk SHALL hold its value.
REQ-022 Per source operand (rs, rt), the block SHALL select 0 if the source is unused, its address is 0, or id_valid is low. Otherwise it SHALL select the lowest matching index k with trk[k].valid and a matching waddr; the youngest entry wins.
REQ-023 The operand SHALL be hazardous if the matched trk[k].is_load is set and k < LOAD_LAT; a hazardous operand SHALL output fwd = 0.
REQ-024 A non-hazardous match SHALL output fwd = k+1; no match SHALL output fwd = 0.
REQ-025 stall SHALL equal hazard_a OR hazard_b, combinationally, with zero-cycle latency.
REQ-026 The enables SHALL be: if_en = id_en = !freeze && !stall; exe_rst = stall && !freeze; back_en = !freeze.
REQ-027 If freeze and a hazard occur together, stall SHALL still be reported, exe_rst SHALL be 0, and stall_cnt SHALL not increment.
REQ-028 stall_cnt SHALL increment when stall && !freeze and saturate at 16'hFFFF. cnt_clr SHALL take priority over the increment.

Reset
REQ-029 While rst is high: all trk entries SHALL be invalid, stall_cnt = 0 and the debug FSM SHALL be in RUN.
REQ-030 Consequently, during reset fwd_a = fwd_b = 0, stall = 0, if_en = id_en = back_en = 1 and exe_rst = 0. Reset asserted mid-stall SHALL clear the stall immediately.

Configuration
REQ-031 With PIPE_DEBUG_EN defined, the block SHALL add inputs debug_en and debug_step (1 bit each) and a debug FSM with states RUN, HALT and STEP:
- RUN -> HALT when debug_en = 1.
- HALT -> STEP on a registered rising edge of debug_step.
- HALT -> RUN when debug_en = 0.
- STEP lasts exactly one cycle, then goes to HALT if debug_en = 1, else RUN.
REQ-032 With PIPE_DEBUG_EN defined, freeze SHALL include state == HALT; STEP SHALL not freeze.
REQ-033 Without PIPE_DEBUG_EN, the debug ports and the FSM SHALL be absent and freeze SHALL equal mem_busy.

Structure
REQ-034 The tracking entry struct, the debug FSM state encoding and the FWD_* select constants SHALL live in a shared package, pipe_pkg.
REQ-035 A single sub-module, hazard_match (one operand: match search plus hazard flag), SHALL be instantiated twice, once for rs and once for rt.

Verification
REQ-036 ALU producer: add r3 in EXE, ID uses rs=r3 -> fwd_a = 1, stall = 0; next cycle with no new producer -> fwd_a = 2.
REQ-037 Load-use: lw r5 in EXE, ID uses rt=r5, LOAD_LAT = 1 -> stall = 1, exe_rst = 1, if_en = 0, stall_cnt 0 -> 1; next cycle -> fwd_b = 2, stall = 0.
REQ-038 Youngest wins: r4 written in both MEM and EXE, ID reads r4 -> fwd_a = 1.
REQ-039 Freeze: mem_busy = 1 during a load-use hazard -> stall = 1, exe_rst = 0, back_en = 0, trk and stall_cnt unchanged.
REQ-040 Edge cases: r0 producer or unused source -> fwd = 0; stall_cnt preset to 16'hFFFF plus one more stall -> stays 16'hFFFF; rst asserted mid-stall -> stall = 0 asynchronously.
REQ-041 PIPE_DEBUG_EN: debug_en = 1 -> back_en = 0; a debug_step pulse -> back_en = 1 for exactly one cycle.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types for the pipeline hazard unit: tracking entry, debug FSM states
// and forwarding select codes.
package pipe_pkg;

  // Widest register address the tracking entry can hold; REG_AW must not exceed it.
  localparam int TRK_AW = 16;

  typedef struct packed {
    logic              valid;
    logic [TRK_AW-1:0] waddr;
    logic              is_load;
  } trk_entry_t;

  typedef enum logic [1:0] {
    DBG_RUN  = 2'd0,
    DBG_HALT = 2'd1,
    DBG_STEP = 2'd2
  } dbg_state_t;

  localparam int FWD_RF  = 0;
  localparam int FWD_EXE = 1;
  localparam int FWD_MEM = 2;
  localparam int FWD_WB  = 3;

endpackage

// File: rtl/hazard_match.sv
// One source operand: finds the youngest in-flight producer of the operand and
// flags a load whose data is not yet available.
import pipe_pkg::*;

module hazard_match #(
  parameter int REG_AW   = 5,
  parameter int DEPTH    = 3,
  parameter int LOAD_LAT = 1,
  parameter int FWD_W    = 2
) (
  input  trk_entry_t [DEPTH-1:0] trk,
  input  logic                   id_valid,
  input  logic                   src_used,
  input  logic [REG_AW-1:0]      src_addr,
  output logic [FWD_W-1:0]       fwd,
  output logic                   hazard
);

  logic [TRK_AW-1:0] src_ext;

  always_comb begin
    src_ext                = '0;
    src_ext[REG_AW-1:0]    = src_addr;
    fwd                    = FWD_W'(FWD_RF);
    hazard                 = 1'b0;
    if (id_valid && src_used && (src_addr != '0)) begin
      // Walk oldest to youngest so the youngest match is the one left standing.
      for (int k = DEPTH - 1; k >= 0; k--) begin
        if (trk[k].valid && (trk[k].waddr == src_ext)) begin
          fwd    = FWD_W'(k + 1);
          hazard = trk[k].is_load && (k < LOAD_LAT);
        end
      end
    end
    if (hazard) fwd = FWD_W'(FWD_RF);
  end

endmodule

// File: rtl/pipe_hazard_unit.sv
// Forwarding/stall control for an in-order pipe with a tracked EXE..WB window.
// Define PIPE_DEBUG_EN to add the debug halt/single-step controller.
import pipe_pkg::*;

module pipe_hazard_unit #(
  parameter  int REG_AW   = 5,
  parameter  int DEPTH    = 3,
  parameter  int LOAD_LAT = 1,
  localparam int FWD_W    = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic              id_rs_used,
  input  logic              id_rt_used,
  input  logic              id_wen,
  input  logic              id_is_load,
  input  logic [REG_AW-1:0] id_rs_addr,
  input  logic [REG_AW-1:0] id_rt_addr,
  input  logic [REG_AW-1:0] id_waddr,
  input  logic              mem_busy,
  input  logic              cnt_clr,
`ifdef PIPE_DEBUG_EN
  input  logic              debug_en,
  input  logic              debug_step,
`endif
  output logic [FWD_W-1:0]  fwd_a,
  output logic [FWD_W-1:0]  fwd_b,
  output logic              stall,
  output logic              if_en,
  output logic              id_en,
  output logic              exe_rst,
  output logic              back_en,
  output logic [15:0]       stall_cnt
);

  trk_entry_t [DEPTH-1:0] trk;
  trk_entry_t             id_entry;
  logic                   freeze;
  logic                   hazard_a;
  logic                   hazard_b;
  logic [15:0]            cnt_q;

`ifdef PIPE_DEBUG_EN
  dbg_state_t dbg_state;
  dbg_state_t dbg_next;
  logic       step_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dbg_state <= DBG_RUN;
      step_q    <= 1'b0;
    end else begin
      dbg_state <= dbg_next;
      step_q    <= debug_step;
    end
  end

  always_comb begin
    dbg_next = dbg_state;
    case (dbg_state)
      DBG_RUN:  if (debug_en) dbg_next = DBG_HALT;
      DBG_HALT: begin
        if (!debug_en)                dbg_next = DBG_RUN;
        else if (debug_step && !step_q) dbg_next = DBG_STEP;
      end
      DBG_STEP: dbg_next = debug_en ? DBG_HALT : DBG_RUN;
      default:  dbg_next = DBG_RUN;
    endcase
  end

  assign freeze = mem_busy || (dbg_state == DBG_HALT);
`else
  assign freeze = mem_busy;
`endif

  always_comb begin
    id_entry                    = '0;
    id_entry.valid              = id_valid && id_wen && (id_waddr != '0);
    id_entry.waddr[REG_AW-1:0]  = id_waddr;
    id_entry.is_load            = id_is_load;
  end

  hazard_match #(.REG_AW(REG_AW), .DEPTH(DEPTH), .LOAD_LAT(LOAD_LAT), .FWD_W(FWD_W)) u_match_rs (
    .trk      (trk),
    .id_valid (id_valid),
    .src_used (id_rs_used),
    .src_addr (id_rs_addr),
    .fwd      (fwd_a),
    .hazard   (hazard_a)
  );

  hazard_match #(.REG_AW(REG_AW), .DEPTH(DEPTH), .LOAD_LAT(LOAD_LAT), .FWD_W(FWD_W)) u_match_rt (
    .trk      (trk),
    .id_valid (id_valid),
    .src_used (id_rt_used),
    .src_addr (id_rt_addr),
    .fwd      (fwd_b),
    .hazard   (hazard_b)
  );

  assign stall   = hazard_a || hazard_b;
  assign if_en   = !freeze && !stall;
  assign id_en   = !freeze && !stall;
  assign exe_rst = stall && !freeze;
  assign back_en = !freeze;

  // A stalled ID slot enters EXE as a bubble while older entries keep moving.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trk <= '0;
    end else if (!freeze) begin
      trk[0] <= stall ? '0 : id_entry;
      for (int i = 1; i < DEPTH; i++) trk[i] <= trk[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                      cnt_q <= '0;
    else if (cnt_clr)                             cnt_q <= '0;
    else if (stall && !freeze && (cnt_q != 16'hFFFF)) cnt_q <= cnt_q + 16'd1;
  end

  assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Directed plus randomized bench for pipe_hazard_unit against a queue-based
// model of the in-flight producer window.
module tb_pipe_hazard_unit;

  localparam int REG_AW   = 5;
  localparam int DEPTH    = 3;
  localparam int LOAD_LAT = 1;
  localparam int FWD_W    = $clog2(DEPTH + 1);

  logic              clk;
  logic              rst;
  logic              id_valid, id_rs_used, id_rt_used, id_wen, id_is_load;
  logic [REG_AW-1:0] id_rs_addr, id_rt_addr, id_waddr;
  logic              mem_busy, cnt_clr;
  logic              debug_en, debug_step;
  logic [FWD_W-1:0]  fwd_a, fwd_b;
  logic              stall, if_en, id_en, exe_rst, back_en;
  logic [15:0]       stall_cnt;

  pipe_hazard_unit #(.REG_AW(REG_AW), .DEPTH(DEPTH), .LOAD_LAT(LOAD_LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .id_valid   (id_valid),
    .id_rs_used (id_rs_used),
    .id_rt_used (id_rt_used),
    .id_wen     (id_wen),
    .id_is_load (id_is_load),
    .id_rs_addr (id_rs_addr),
    .id_rt_addr (id_rt_addr),
    .id_waddr   (id_waddr),
    .mem_busy   (mem_busy),
    .cnt_clr    (cnt_clr),
`ifdef PIPE_DEBUG_EN
    .debug_en   (debug_en),
    .debug_step (debug_step),
`endif
    .fwd_a      (fwd_a),
    .fwd_b      (fwd_b),
    .stall      (stall),
    .if_en      (if_en),
    .id_en      (id_en),
    .exe_rst    (exe_rst),
    .back_en    (back_en),
    .stall_cnt  (stall_cnt)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  int n_vec = 0;
  int n_mis = 0;
  int cyc   = 0;

  // reference model: in-flight producers, youngest first
  typedef struct {
    bit v;
    int a;
    bit ld;
  } prod_t;

  prod_t mq[$];
  int    m_cnt;

  function automatic void m_reset();
    prod_t e;
    e.v = 0; e.a = 0; e.ld = 0;
    mq.delete();
    for (int i = 0; i < DEPTH; i++) mq.push_back(e);
    m_cnt = 0;
  endfunction

  function automatic void m_sel(input bit used, input int addr, output int fwd, output bit haz);
    fwd = 0;
    haz = 0;
    if (used && id_valid && addr != 0) begin
      for (int k = 0; k < DEPTH; k++) begin
        if (mq[k].v && mq[k].a == addr) begin
          if (mq[k].ld && k < LOAD_LAT) haz = 1;
          else fwd = k + 1;
          break;
        end
      end
    end
  endfunction

  function automatic bit m_stall();
    int f; bit ha, hb;
    m_sel(id_rs_used, int'(id_rs_addr), f, ha);
    m_sel(id_rt_used, int'(id_rt_addr), f, hb);
    return ha | hb;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s@%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  // driver tasks
  task automatic set_id(input bit v, input bit rsu, input int rs, input bit rtu, input int rt,
                        input bit wen, input int wa, input bit ld);
    id_valid   = v;
    id_rs_used = rsu;
    id_rs_addr = REG_AW'(rs);
    id_rt_used = rtu;
    id_rt_addr = REG_AW'(rt);
    id_wen     = wen;
    id_waddr   = REG_AW'(wa);
    id_is_load = ld;
  endtask

  task automatic eval();
    int fa, fb; bit ha, hb, st, fr;
    #1;
    m_sel(id_rs_used, int'(id_rs_addr), fa, ha);
    m_sel(id_rt_used, int'(id_rt_addr), fb, hb);
    st = ha | hb;
    fr = mem_busy;
    chk("fwd_a",     32'(fwd_a),     32'(fa));
    chk("fwd_b",     32'(fwd_b),     32'(fb));
    chk("stall",     32'(stall),     32'(st));
    chk("if_en",     32'(if_en),     32'(!fr && !st));
    chk("id_en",     32'(id_en),     32'(!fr && !st));
    chk("exe_rst",   32'(exe_rst),   32'(st && !fr));
    chk("back_en",   32'(back_en),   32'(!fr));
    chk("stall_cnt", 32'(stall_cnt), 32'(m_cnt));
  endtask

  task automatic tick();
    bit st, fr;
    prod_t e;
    st = m_stall();
    fr = mem_busy;
    @(posedge clk);
    if (cnt_clr) m_cnt = 0;
    else if (st && !fr && m_cnt != 32'hFFFF) m_cnt++;
    if (!fr) begin
      e.v  = !st && id_valid && id_wen && (id_waddr != 0);
      e.a  = int'(id_waddr);
      e.ld = !st && id_is_load;
      mq.push_front(e);
      void'(mq.pop_back());
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic nops(input int n);
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < n; i++) begin
      eval();
      tick();
    end
  endtask

  initial begin
    int snap;
    rst = 1'b1;
    mem_busy = 1'b0;
    cnt_clr = 1'b0;
    debug_en = 1'b0;
    debug_step = 1'b0;
    set_id(1, 1, 3, 1, 5, 1, 7, 1);
    m_reset();
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_fwd_a",   32'(fwd_a),     0);
    chk("rst_fwd_b",   32'(fwd_b),     0);
    chk("rst_stall",   32'(stall),     0);
    chk("rst_if_en",   32'(if_en),     1);
    chk("rst_id_en",   32'(id_en),     1);
    chk("rst_back_en", 32'(back_en),   1);
    chk("rst_exe_rst", 32'(exe_rst),   0);
    chk("rst_cnt",     32'(stall_cnt), 0);
    rst = 1'b0;
    @(negedge clk);

    // ALU producer forwarded from EXE then MEM
    set_id(1, 0, 0, 0, 0, 1, 3, 0); eval(); tick();
    set_id(1, 1, 3, 0, 0, 0, 0, 0); eval();
    chk("alu_exe_fwd", 32'(fwd_a), 1);
    chk("alu_exe_stall", 32'(stall), 0);
    tick();
    eval();
    chk("alu_mem_fwd", 32'(fwd_a), 2);
    tick();

    // load-use stall then forward from MEM
    nops(3);
    set_id(1, 0, 0, 0, 0, 1, 5, 1); eval(); tick();
    set_id(1, 0, 0, 1, 5, 0, 0, 0); eval();
    chk("lu_stall", 32'(stall), 1);
    chk("lu_exe_rst", 32'(exe_rst), 1);
    chk("lu_if_en", 32'(if_en), 0);
    chk("lu_cnt0", 32'(stall_cnt), 0);
    tick();
    eval();
    chk("lu_cnt1", 32'(stall_cnt), 1);
    chk("lu_fwd_b", 32'(fwd_b), 2);
    chk("lu_stall_gone", 32'(stall), 0);
    tick();

    // youngest producer wins; unused source and r0 select the register file
    nops(3);
    set_id(1, 0, 0, 0, 0, 1, 4, 0); eval(); tick();
    set_id(1, 0, 0, 0, 0, 1, 4, 0); eval(); tick();
    set_id(1, 1, 4, 0, 4, 0, 0, 0); eval();
    chk("young_fwd_a", 32'(fwd_a), 1);
    chk("unused_fwd_b", 32'(fwd_b), 0);
    tick();
    set_id(1, 0, 0, 0, 0, 1, 0, 0); eval(); tick();
    set_id(1, 1, 0, 1, 0, 0, 0, 0); eval();
    chk("r0_fwd_a", 32'(fwd_a), 0);
    chk("r0_fwd_b", 32'(fwd_b), 0);
    tick();

    // freeze during load-use
    nops(3);
    set_id(1, 0, 0, 0, 0, 1, 5, 1); eval(); tick();
    set_id(1, 0, 0, 1, 5, 0, 0, 0);
    mem_busy = 1'b1;
    eval();
    snap = m_cnt;
    chk("frz_stall", 32'(stall), 1);
    chk("frz_exe_rst", 32'(exe_rst), 0);
    chk("frz_back_en", 32'(back_en), 0);
    tick();
    eval();
    chk("frz_held_stall", 32'(stall), 1);
    chk("frz_held_cnt", 32'(stall_cnt), 32'(snap));
    tick();
    mem_busy = 1'b0;
    eval(); tick();
    eval();
    chk("frz_after_cnt", 32'(stall_cnt), 32'(snap + 1));
    tick();

    // saturation
    nops(3);
    force dut.cnt_q = 16'hFFFE;
    #1;
    release dut.cnt_q;
    m_cnt = 32'hFFFE;
    for (int r = 0; r < 2; r++) begin
      set_id(1, 0, 0, 0, 0, 1, 5, 1); eval(); tick();
      set_id(1, 0, 0, 1, 5, 0, 0, 0); eval(); tick();
    end
    eval();
    chk("sat_cnt", 32'(stall_cnt), 32'hFFFF);
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    eval();
    chk("clr_cnt", 32'(stall_cnt), 0);

    // reset asserted in the middle of a stall
    nops(3);
    set_id(1, 0, 0, 0, 0, 1, 5, 1); eval(); tick();
    set_id(1, 0, 0, 1, 5, 0, 0, 0); eval();
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_stall", 32'(stall), 0);
    chk("mid_rst_exe_rst", 32'(exe_rst), 0);
    chk("mid_rst_if_en", 32'(if_en), 1);
    chk("mid_rst_cnt", 32'(stall_cnt), 0);
    m_reset();
    @(negedge clk);
    rst = 1'b0;

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      set_id($urandom_range(0, 3) != 0, $urandom_range(0, 1), $urandom_range(0, 7),
             $urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 3) != 0,
             $urandom_range(0, 7), $urandom_range(0, 4) < 2);
      mem_busy = ($urandom_range(0, 4) == 0);
      cnt_clr  = ($urandom_range(0, 19) == 0);
      eval();
      tick();
    end
    mem_busy = 1'b0;
    cnt_clr  = 1'b0;

`ifdef PIPE_DEBUG_EN
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    debug_en = 1'b1;
    #1;
    chk("dbg_run_back_en", 32'(back_en), 1);
    @(negedge clk);
    #1;
    chk("dbg_halt_back_en", 32'(back_en), 0);
    debug_step = 1'b1;
    #1;
    chk("dbg_halt_step_in", 32'(back_en), 0);
    @(negedge clk);
    debug_step = 1'b0;
    #1;
    chk("dbg_step_back_en", 32'(back_en), 1);
    @(negedge clk);
    #1;
    chk("dbg_rehalt_back_en", 32'(back_en), 0);
    debug_en = 1'b0;
    @(negedge clk);
    #1;
    chk("dbg_resume_back_en", 32'(back_en), 1);
`endif

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
